// File: rtl/wb_ibus_dbus_arbiter.sv
// Two-master (instruction/data) to one-slave Wishbone B4 classic arbiter with
// round-robin or fixed-priority grant and a bus-timeout watchdog.
module wb_ibus_dbus_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int ROUND_ROBIN = 1,
    parameter int TIMEOUT     = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic [AW-1:0]   wbm0_adr_i,
    input  logic [DW-1:0]   wbm0_dat_i,
    input  logic [DW/8-1:0] wbm0_sel_i,
    input  logic            wbm0_we_i,
    input  logic            wbm0_cyc_i,
    input  logic            wbm0_stb_i,
    output logic [DW-1:0]   wbm0_dat_o,
    output logic            wbm0_ack_o,
    output logic            wbm0_err_o,
    output logic            wbm0_rty_o,
    input  logic [AW-1:0]   wbm1_adr_i,
    input  logic [DW-1:0]   wbm1_dat_i,
    input  logic [DW/8-1:0] wbm1_sel_i,
    input  logic            wbm1_we_i,
    input  logic            wbm1_cyc_i,
    input  logic            wbm1_stb_i,
    output logic [DW-1:0]   wbm1_dat_o,
    output logic            wbm1_ack_o,
    output logic            wbm1_err_o,
    output logic            wbm1_rty_o,
    output logic [AW-1:0]   wbs_adr_o,
    output logic [DW-1:0]   wbs_dat_o,
    output logic [DW/8-1:0] wbs_sel_o,
    output logic            wbs_we_o,
    output logic            wbs_cyc_o,
    output logic            wbs_stb_o,
    input  logic [DW-1:0]   wbs_dat_i,
    input  logic            wbs_ack_i,
    input  logic            wbs_err_i,
    input  logic            wbs_rty_i,
    output logic [1:0]      grant_o,
    output logic            timeout_o
);

    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_q, last_d;   // 0 = m0 owned last, 1 = m1 owned last
    logic [15:0] cnt_q, cnt_d;
    logic        g0, g1;
    logic        req_cyc, req_stb, slv_resp, active, expire;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Owner keeps the bus while it holds cyc; release hands straight to the other master.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (wbm0_cyc_i && wbm1_cyc_i)
                    state_d = (ROUND_ROBIN == 0 || last_q) ? GRANT0 : GRANT1;
                else if (wbm0_cyc_i)
                    state_d = GRANT0;
                else if (wbm1_cyc_i)
                    state_d = GRANT1;
            end
            GRANT0: if (!wbm0_cyc_i) state_d = wbm1_cyc_i ? GRANT1 : IDLE;
            GRANT1: if (!wbm1_cyc_i) state_d = wbm0_cyc_i ? GRANT0 : IDLE;
            default: state_d = IDLE;
        endcase

        last_d = last_q;
        if (state_d != state_q) begin
            if (state_d == GRANT0) last_d = 1'b0;
            if (state_d == GRANT1) last_d = 1'b1;
        end
    end

    always_comb begin
        g0       = (state_q == GRANT0);
        g1       = (state_q == GRANT1);
        grant_o  = {g1, g0};
        req_cyc  = (g0 & wbm0_cyc_i) | (g1 & wbm1_cyc_i);
        req_stb  = (g0 & wbm0_stb_i) | (g1 & wbm1_stb_i);
        slv_resp = wbs_ack_i | wbs_err_i | wbs_rty_i;
        active   = req_cyc & req_stb & ~slv_resp;
        // A real response in the expiry cycle wins because active excludes it.
        expire   = (TIMEOUT != 0) && active && (cnt_q == TO_LIMIT);

        if (TIMEOUT == 0 || !active || expire || state_d != state_q)
            cnt_d = 16'd0;
        else
            cnt_d = cnt_q + 16'd1;

        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_sel_o = '0;
        wbs_we_o  = 1'b0;
        if (g0) begin
            wbs_adr_o = wbm0_adr_i;
            wbs_dat_o = wbm0_dat_i;
            wbs_sel_o = wbm0_sel_i;
            wbs_we_o  = wbm0_we_i;
        end else if (g1) begin
            wbs_adr_o = wbm1_adr_i;
            wbs_dat_o = wbm1_dat_i;
            wbs_sel_o = wbm1_sel_i;
            wbs_we_o  = wbm1_we_i;
        end
        wbs_cyc_o = req_cyc;
        wbs_stb_o = req_stb & ~expire;
        timeout_o = expire;

        wbm0_dat_o = wbs_dat_i;
        wbm1_dat_o = wbs_dat_i;
        wbm0_ack_o = g0 & wbs_ack_i;
        wbm1_ack_o = g1 & wbs_ack_i;
        wbm0_err_o = g0 & (wbs_err_i | expire);
        wbm1_err_o = g1 & (wbs_err_i | expire);
        wbm0_rty_o = g0 & wbs_rty_i;
        wbm1_rty_o = g1 & wbs_rty_i;
    end

endmodule

// File: doc/wb_ibus_dbus_arbiter.md
Name: wb_ibus_dbus_arbiter

Overview:
- Two-master to one-slave Wishbone B4 classic arbiter.
- Lets the vscale instruction port (master 0) and data port (master 1) share a single slave, e.g. a unified SRAM or boot ROM, behind one intercon slot.
- Grant sequencing uses round-robin or fixed priority.
- A bus-timeout watchdog terminates stalled cycles with err so the core never hangs on an unresponsive slave.

Parameters:
- AW, 32, address width.
- DW, 32, data width; select width is DW/8.
- ROUND_ROBIN, 1; 1 = round-robin between masters, 0 = fixed priority with master 0 (instruction) winning.
- TIMEOUT, 255; cycles without slave ack/err/rty before forced err. 0 disables the watchdog. Legal range 0..65535.

Ports:
- wb_clk_i  in  1  bus clock
- wb_rst_i  in  1  asynchronous active-high reset
- wbm0_adr_i in AW; wbm0_dat_i in DW; wbm0_sel_i in DW/8; wbm0_we_i in 1; wbm0_cyc_i in 1; wbm0_stb_i in 1  master 0 request
- wbm0_dat_o out DW; wbm0_ack_o out 1; wbm0_err_o out 1; wbm0_rty_o out 1  master 0 response
- wbm1_adr_i, wbm1_dat_i, wbm1_sel_i, wbm1_we_i, wbm1_cyc_i, wbm1_stb_i, wbm1_dat_o, wbm1_ack_o, wbm1_err_o, wbm1_rty_o  same as master 0, for master 1
- wbs_adr_o out AW; wbs_dat_o out DW; wbs_sel_o out DW/8; wbs_we_o out 1; wbs_cyc_o out 1; wbs_stb_o out 1  slave request
- wbs_dat_i in DW; wbs_ack_i in 1; wbs_err_i in 1; wbs_rty_i in 1  slave response
- grant_o  out  2  one-hot current owner: bit0 = m0, bit1 = m1, 00 = idle
- timeout_o  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset state: IDLE; last_grant = m1, so m0 wins the first contention; watchdog counter = 0.
- Reset outputs: grant_o = 00, timeout_o = 0, all wbs_* control outputs 0, all wbmX ack/err/rty = 0.
- State machine, registered:
  - IDLE, both cyc: grant m0 if ROUND_ROBIN=0; if ROUND_ROBIN=1, grant the master that is not last_grant.
  - IDLE, single cyc: grant that master.
  - IDLE, no cyc: stay in IDLE.
  - GRANTx, wbmx_cyc_i = 0: go to GRANTy if wbmy_cyc_i = 1, else IDLE. The handoff needs no idle bubble.
  - GRANTx, wbmx_cyc_i = 1: hold GRANTx. No preemption, so multi-beat cycles holding cyc stay atomic.
  - last_grant updates on every transition into GRANTx.
- Arbitration latency: one cycle from cyc assertion in IDLE to wbs_cyc_o.
- Datapath routing, combinational from the registered grant:
  - wbs_* request outputs = granted master's inputs.
  - In IDLE, wbs_cyc_o = wbs_stb_o = 0; adr/dat/sel/we drive 0.
  - wbs_dat_i fans out to both wbmX_dat_o.
  - ack/err/rty route only to the granted master; the non-granted master sees 0.
- Slave responses arriving while IDLE are ignored.
- Watchdog, when TIMEOUT != 0:
  - 16-bit counter increments each cycle with wbs_cyc_o & wbs_stb_o high and none of wbs_ack_i/err_i/rty_i high.
  - Counter clears on any slave response, on a grant change, or when stb is low.
  - When the counter reaches TIMEOUT, in that same cycle: force the granted master's err_o = 1, mask wbs_stb_o to 0, pulse timeout_o, clear the counter.
  - A slave ack coinciding with expiry takes precedence: ack is passed through, no err, no timeout_o.
- TIMEOUT = 0: the counter is held at 0 and timeout_o stays 0.
- Simultaneous release and re-request by the owner: if the owner drops cyc for one cycle while the other master requests, ownership moves to the other master.
- Reset asserted mid-cycle: immediate return to reset state, outputs as listed. Masters must restart their cycles.

Test Plan:
- Reset, then m0 reads adr 0x0000_0100 alone, slave acks with dat 0xDEAD_BEEF after 2 cycles -> grant_o = 01 one cycle after cyc; wbm0_ack_o = 1 with wbm0_dat_o = 0xDEAD_BEEF; wbm1_ack_o stays 0.
- ROUND_ROBIN=1, both masters request continuously with single-beat cycles dropping cyc after ack -> grants alternate m0, m1, m0, m1 with no IDLE bubble between owners.
- ROUND_ROBIN=0, both request continuously -> m0 owns every cycle; m1 granted only when m0 cyc = 0.
- m1 writes 0x1234_5678 with sel = 0011 while m0 requests; slave acks after 3 cycles -> wbs_dat_o/sel/we match m1 throughout; m0 waits, then gets the grant the cycle after m1 drops cyc.
- TIMEOUT=8, slave never responds to m1 -> wbm1_err_o and timeout_o pulse exactly 8 cycles after wbs_stb_o rises; wbs_stb_o is 0 that cycle; the next request is served normally.
- TIMEOUT=8 with slave ack on exactly cycle 8, then reset asserted mid-cycle on a later transaction -> first case: ack only, no err or timeout; second case: grant_o = 00 and wbs_cyc_o = 0 asynchronously on reset.
